// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions: FSM encoding, multiply latency and the
// decoder funct codes that select MULTU / MFHI / MFLO.
package cpu_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int MULTU_LAT = WIDTH_DEF;

  localparam logic [5:0] FUNCT_MULTU = 6'd25;
  localparam logic [5:0] FUNCT_MFHI  = 6'd16;
  localparam logic [5:0] FUNCT_MFLO  = 6'd18;

  typedef enum logic {IDLE, MUL} state_t;
endpackage

// File: rtl/multu_shift_add_core.sv
// Iterative shift-add unsigned multiplier: one partial-product step per cycle,
// WIDTH steps per operation; fin marks the edge that produces the final product.
module multu_shift_add_core
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               flush,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic               busy,
  output logic               fin,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nx;
  logic             load;
  logic [WIDTH-1:0] mcand;
  logic [2*WIDTH:0] p;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   addend, sum;

  // Upper WIDTH+1 bits accumulate so the carry out of the add survives the shift.
  assign addend  = p[0] ? {1'b0, mcand} : '0;
  assign sum     = p[2*WIDTH:WIDTH] + addend;
  assign product = {sum, p[WIDTH-1:1]};
  assign busy    = (state == MUL);

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    fin      = 1'b0;
    case (state)
      IDLE: if (start && !flush) begin
        state_nx = MUL;
        load     = 1'b1;
      end
      MUL: if (flush) begin
        state_nx = IDLE;
      end else if (cnt == CW'(1)) begin
        state_nx = IDLE;
        fin      = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      mcand <= '0;
      p     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        mcand <= src_a;
        p     <= {(WIDTH + 1)'(0), src_b};
        cnt   <= CW'(WIDTH);
      end else if (state == MUL && !flush) begin
        p   <= {1'b0, product};
        cnt <= cnt - CW'(1);
      end
    end
  end
endmodule

// File: rtl/multu_hilo_unit.sv
// Architectural HI/LO with MFHI/MFLO read mux and hazard stall around the
// iterative multiplier core.
module multu_hilo_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             rd_hi,
  input  logic             rd_lo,
  output logic [WIDTH-1:0] hilo_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);
  logic               fin;
  logic [2*WIDTH-1:0] product;

  multu_shift_add_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .flush   (flush),
    .src_a   (src_a),
    .src_b   (src_b),
    .busy    (busy),
    .fin     (fin),
    .product (product)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= fin;
      if (fin) begin
        hi <= product[2*WIDTH-1:WIDTH];
        lo <= product[WIDTH-1:0];
      end
    end
  end

  // rd_hi wins if the decoder ever raises both selects.
  assign hilo_data = rd_hi ? hi : (rd_lo ? lo : '0);
  assign stall     = busy & (rd_hi | rd_lo | start);
endmodule
